// File: rtl/spi_pkg.sv
// spi_pkg: shared widths, slave FSM state type and frame-size helper for the
// SPI master/slave pair.
package spi_pkg;

    localparam int DWIDTH    = 32;
    localparam int AWIDTH    = 12;
    // WRITE flag + 2-bit SIZE + address
    localparam int CMD_NBITS = AWIDTH + 3;
    // Wide enough to count the longest frame segment (32 data bits)
    localparam int CNT_W     = 6;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        WDATA,
        RDATA,
        DONE
    } slv_state_t;

    // Number of DATA bits on the wire for a SIZE code; code 3 still clocks 32
    function automatic logic [CNT_W-1:0] size_to_nbits(input logic [1:0] size);
        case (size)
            2'd0:    size_to_nbits = 6'd8;
            2'd1:    size_to_nbits = 6'd16;
            default: size_to_nbits = 6'd32;
        endcase
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: multi-flop synchronizer for asynchronous SPI pins. One bit
// (d_edge) also gets single-clk rise/fall pulses; the d_plain bits are only
// synchronized, all with identical latency so they stay aligned.
module spi_sync_edge #(
    parameter int               STAGES    = 2,
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RST_PLAIN = '0,
    parameter logic             RST_EDGE  = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             d_edge,
    input  logic [WIDTH-1:0] d_plain,
    output logic [WIDTH-1:0] q_plain,
    output logic             rise,
    output logic             fall
);
    // Stage vector: edge bit in the MSB, plain bits below it
    logic [WIDTH:0] chain_reg [STAGES];
    logic           edge_prev_reg;

    // First stage captures the raw pins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain_reg[0] <= {RST_EDGE, RST_PLAIN};
        end else begin
            chain_reg[0] <= {d_edge, d_plain};
        end
    end

    genvar gi;
    generate
        for (gi = 1; gi < STAGES; gi++) begin : g_stage
            // Further stages settle metastability
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    chain_reg[gi] <= {RST_EDGE, RST_PLAIN};
                end else begin
                    chain_reg[gi] <= chain_reg[gi-1];
                end
            end
        end
    endgenerate

    // Previous synchronized value of the edge bit for transition detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            edge_prev_reg <= RST_EDGE;
        end else begin
            edge_prev_reg <= chain_reg[STAGES-1][WIDTH];
        end
    end

    assign q_plain = chain_reg[STAGES-1][WIDTH-1:0];
    assign rise    = chain_reg[STAGES-1][WIDTH]  & ~edge_prev_reg;
    assign fall    = ~chain_reg[STAGES-1][WIDTH] &  edge_prev_reg;

endmodule

// File: rtl/spi_slave_regs.sv
// spi_slave_regs: SPI mode-0 slave that decodes
// [WRITE | SIZE(2) | ADDR | DATA(8/16/32)] frames into a local byte memory
// and shifts read data back on miso. Pins are oversampled on clk.
// Optional build macro SPI_SLAVE_ERR_EN adds a sticky err_flags[1:0] output
// (bit0 = aborted frame, bit1 = SIZE code 3 seen).
module spi_slave_regs
    import spi_pkg::*;
#(
    parameter int MEM_AW      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sck,
    input  logic              mosi,
    input  logic              ss_n,
    output logic              miso,
    output logic              wr_strobe,
    output logic [MEM_AW-1:0] wr_addr,
    output logic [DWIDTH-1:0] wr_data,
    output logic [1:0]        wr_size,
`ifdef SPI_SLAVE_ERR_EN
    output logic [1:0]        err_flags,
`endif
    output logic              busy
);
    localparam logic [CNT_W-1:0] CMD_LAST = CNT_W'(CMD_NBITS - 1);

    logic [1:0] sync_plain;
    logic       ss_s;
    logic       mosi_s;
    logic       sck_rise;
    logic       sck_fall;

    // ss_n resets high (deselected) so miso floats straight out of reset
    spi_sync_edge #(
        .STAGES    (SYNC_STAGES),
        .WIDTH     (2),
        .RST_PLAIN (2'b10),
        .RST_EDGE  (1'b0)
    ) u_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .d_edge  (sck),
        .d_plain ({ss_n, mosi}),
        .q_plain (sync_plain),
        .rise    (sck_rise),
        .fall    (sck_fall)
    );
    assign ss_s   = sync_plain[1];
    assign mosi_s = sync_plain[0];

    slv_state_t           state_reg;
    logic [CNT_W-1:0]     bit_cnt_reg;
    logic [CNT_W-1:0]     nbits_reg;
    logic [CMD_NBITS-2:0] cmd_sr_reg;
    logic [DWIDTH-2:0]    data_sr_reg;
    logic [DWIDTH-1:0]    tx_sr_reg;
    logic [1:0]           size_reg;
    logic [MEM_AW-1:0]    addr_reg;
    logic                 rd_pending_reg;
    logic                 wr_strobe_reg;
    logic [MEM_AW-1:0]    wr_addr_reg;
    logic [DWIDTH-1:0]    wr_data_reg;
    logic [1:0]           wr_size_reg;
`ifdef SPI_SLAVE_ERR_EN
    logic [1:0]           err_reg;
`endif

    logic [7:0] mem [2**MEM_AW];

    logic [DWIDTH-1:0] wword;
    logic [DWIDTH-1:0] wword_left;
    logic [DWIDTH-1:0] rd_raw;
    logic [DWIDTH-1:0] rd_word;
    logic              last_wbit;
    logic              commit;
    logic [MEM_AW-1:0] byte_addr [4];
    logic [7:0]        wr_byte [4];
    logic [3:0]        byte_en;

    // The shift register was cleared on WDATA entry, so this is right-aligned
    // and zero-extended once the final bit arrives.
    assign wword     = {data_sr_reg, mosi_s};
    assign last_wbit = (state_reg == WDATA) && sck_rise &&
                       (bit_cnt_reg == nbits_reg - CNT_W'(1));
    assign commit    = last_wbit && !ss_s && (size_reg != 2'd3);

    // Left-align the received word so each byte lane is a fixed slice
    always_comb begin
        case (size_reg)
            2'd0:    wword_left = wword << 24;
            2'd1:    wword_left = wword << 16;
            default: wword_left = wword;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            // Lane gi is the gi-th byte in big-endian order; addresses wrap
            assign byte_addr[gi] = addr_reg + MEM_AW'(gi);
            assign wr_byte[gi]   = wword_left[DWIDTH-1-8*gi -: 8];
            assign byte_en[gi]   = commit && (CNT_W'(8*gi) < nbits_reg);
            assign rd_raw[DWIDTH-1-8*gi -: 8] = mem[byte_addr[gi]];
        end
    endgenerate

    // Keep only the bytes the read size asks for; SIZE 3 returns zero
    always_comb begin
        case (size_reg)
            2'd0:    rd_word = {rd_raw[31:24], 24'd0};
            2'd1:    rd_word = {rd_raw[31:16], 16'd0};
            2'd2:    rd_word = rd_raw;
            default: rd_word = '0;
        endcase
    end

    // Byte memory write port: up to four lanes per commit
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (byte_en[i]) begin
                mem[byte_addr[i]] <= wr_byte[i];
            end
        end
    end

    // Frame FSM; a deselect in any state drops the frame and returns to IDLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            bit_cnt_reg    <= '0;
            nbits_reg      <= '0;
            cmd_sr_reg     <= '0;
            data_sr_reg    <= '0;
            tx_sr_reg      <= '0;
            size_reg       <= '0;
            addr_reg       <= '0;
            rd_pending_reg <= 1'b0;
            wr_strobe_reg  <= 1'b0;
            wr_addr_reg    <= '0;
            wr_data_reg    <= '0;
            wr_size_reg    <= '0;
`ifdef SPI_SLAVE_ERR_EN
            err_reg        <= '0;
`endif
        end else begin
            wr_strobe_reg  <= 1'b0;
            rd_pending_reg <= 1'b0;
            if (ss_s) begin
                state_reg <= IDLE;
`ifdef SPI_SLAVE_ERR_EN
                if (state_reg inside {CMD, WDATA, RDATA}) begin
                    err_reg[0] <= 1'b1;
                end
`endif
            end else begin
                case (state_reg)
                    IDLE: begin
                        // Any sck edge seen this cycle is deliberately ignored
                        state_reg   <= CMD;
                        bit_cnt_reg <= '0;
                    end
                    CMD: begin
                        if (sck_rise) begin
                            cmd_sr_reg  <= {cmd_sr_reg[CMD_NBITS-3:0], mosi_s};
                            bit_cnt_reg <= bit_cnt_reg + CNT_W'(1);
                            if (bit_cnt_reg == CMD_LAST) begin
                                size_reg    <= cmd_sr_reg[CMD_NBITS-3 -: 2];
                                nbits_reg   <= size_to_nbits(cmd_sr_reg[CMD_NBITS-3 -: 2]);
                                addr_reg    <= {cmd_sr_reg[MEM_AW-2:0], mosi_s};
                                bit_cnt_reg <= '0;
                                data_sr_reg <= '0;
`ifdef SPI_SLAVE_ERR_EN
                                if (cmd_sr_reg[CMD_NBITS-3 -: 2] == 2'd3) begin
                                    err_reg[1] <= 1'b1;
                                end
`endif
                                if (cmd_sr_reg[CMD_NBITS-2]) begin
                                    state_reg <= WDATA;
                                end else begin
                                    // Memory is fetched on the next clk, well
                                    // before the master's first data sample
                                    state_reg      <= RDATA;
                                    rd_pending_reg <= 1'b1;
                                end
                            end
                        end
                    end
                    WDATA: begin
                        if (sck_rise) begin
                            data_sr_reg <= {data_sr_reg[DWIDTH-3:0], mosi_s};
                            bit_cnt_reg <= bit_cnt_reg + CNT_W'(1);
                            if (last_wbit) begin
                                state_reg <= DONE;
                                if (commit) begin
                                    wr_strobe_reg <= 1'b1;
                                    wr_addr_reg   <= addr_reg;
                                    wr_data_reg   <= wword;
                                    wr_size_reg   <= size_reg;
                                end
                            end
                        end
                    end
                    RDATA: begin
                        if (rd_pending_reg) begin
                            tx_sr_reg <= rd_word;
                        end else if (sck_rise) begin
                            bit_cnt_reg <= bit_cnt_reg + CNT_W'(1);
                        end else if (sck_fall && bit_cnt_reg != '0) begin
                            // The fall ending the address phase must not shift
                            tx_sr_reg <= {tx_sr_reg[DWIDTH-2:0], 1'b0};
                            if (bit_cnt_reg == nbits_reg) begin
                                state_reg <= DONE;
                            end
                        end
                    end
                    DONE: begin
                        state_reg <= DONE;
                    end
                    default: begin
                        state_reg <= IDLE;
                    end
                endcase
            end
        end
    end

    assign wr_strobe = wr_strobe_reg;
    assign wr_addr   = wr_addr_reg;
    assign wr_data   = wr_data_reg;
    assign wr_size   = wr_size_reg;
    assign busy      = (state_reg != IDLE);
`ifdef SPI_SLAVE_ERR_EN
    assign err_flags = err_reg;
`endif
    assign miso = ss_s ? 1'bz :
                  ((state_reg == RDATA && !rd_pending_reg) ? tx_sr_reg[DWIDTH-1] : 1'b0);

endmodule

// File: tb/tb_spi_slave_regs.sv
// tb_spi_slave_regs: random and directed SPI frames against a byte-array
// reference model; expected commits/reads are queued at issue time and a
// separate monitor compares them as the DUT produces them.
`timescale 1ns/1ps
module tb_spi_slave_regs;
    import spi_pkg::*;

    localparam int MEM_AW = 8;
    localparam int HALF   = 4;   // sck half period in clk cycles (sck = clk/8)

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              sck = 1'b0;
    logic              mosi = 1'b0;
    logic              ss_n = 1'b1;
    wire               miso;
    logic              wr_strobe;
    logic [MEM_AW-1:0] wr_addr;
    logic [DWIDTH-1:0] wr_data;
    logic [1:0]        wr_size;
    logic              busy;
`ifdef SPI_SLAVE_ERR_EN
    logic [1:0]        err_flags;
`endif

    spi_slave_regs #(.MEM_AW(MEM_AW), .SYNC_STAGES(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sck       (sck),
        .mosi      (mosi),
        .ss_n      (ss_n),
        .miso      (miso),
        .wr_strobe (wr_strobe),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_size   (wr_size),
`ifdef SPI_SLAVE_ERR_EN
        .err_flags (err_flags),
`endif
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct { logic [7:0] addr; logic [31:0] data; logic [1:0] size; } wr_exp_t;
    typedef struct { logic [31:0] data; logic [31:0] mask; } rd_exp_t;

    wr_exp_t     exp_wr_q[$];
    rd_exp_t     exp_rd_q[$];
    logic [31:0] rd_obs_q[$];
    logic [7:0]  wr_hist_q[$];
    logic [7:0]  ref_mem   [256];
    logic        ref_known [256];
    int          errors = 0;
    int          checks = 0;
    int          strobe_cnt = 0;
    int          exp_strobes = 0;
    logic        saw_size3 = 1'b0;
    wr_exp_t     mon_w;
    rd_exp_t     mon_r;
    logic [31:0] mon_obs;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: commits on wr_strobe, reads as the master captures them
    always @(negedge clk) begin
        if (rst_n && wr_strobe) begin
            strobe_cnt++;
            if (exp_wr_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe: got addr 0x%02h data 0x%08h expected no commit", wr_addr, wr_data);
            end else begin
                mon_w = exp_wr_q.pop_front();
                check("wr_addr", 32'(wr_addr), 32'(mon_w.addr));
                check("wr_data", wr_data, mon_w.data);
                check("wr_size", 32'(wr_size), 32'(mon_w.size));
                $display("commit addr=0x%02h data=0x%08h size=%0d", wr_addr, wr_data, wr_size);
            end
        end
        if (rd_obs_q.size() > 0) begin
            mon_obs = rd_obs_q.pop_front();
            if (exp_rd_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_read: got 0x%08h expected no read", mon_obs);
            end else begin
                mon_r = exp_rd_q.pop_front();
                check("rd_data", mon_obs & mon_r.mask, mon_r.data & mon_r.mask);
                $display("read data=0x%08h mask=0x%08h", mon_obs, mon_r.mask);
            end
        end
    end

    // Mode-0 master: mosi changes on falls, miso captured just before each rise
    task automatic spi_frame(input logic wr, input logic [1:0] size, input logic [11:0] addr,
                             input logic [31:0] data, input int stop_after, input logic record);
        int          n;
        int          total;
        logic [46:0] word;
        logic [31:0] rx;
        n     = (size == 2'd0) ? 8 : (size == 2'd1) ? 16 : 32;
        total = 15 + n;
        word  = {wr, size, addr, data << (32 - n)};
        rx    = '0;
        @(negedge clk);
        ss_n = 1'b0;
        repeat (HALF) @(negedge clk);
        for (int i = 0; i < total && i < stop_after; i++) begin
            mosi = word[46 - i];
            repeat (HALF) @(negedge clk);
            if (i >= 15) rx = {rx[30:0], miso};
            sck = 1'b1;
            repeat (HALF) @(negedge clk);
            sck = 1'b0;
        end
        repeat (HALF) @(negedge clk);
        ss_n = 1'b1;
        if (record) rd_obs_q.push_back(rx);
    endtask

    // Issue a complete frame, queueing what the reference model predicts
    task automatic do_frame(input logic wr, input logic [1:0] size, input logic [11:0] addr,
                            input logic [31:0] data);
        int          nb;
        logic [31:0] d;
        logic [31:0] ev;
        logic [31:0] em;
        logic [7:0]  a;
        logic [7:0]  ai;
        nb = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        d  = (nb == 4) ? data : (data & ((32'd1 << (8 * nb)) - 32'd1));
        a  = addr[7:0];
        if (size == 2'd3) saw_size3 = 1'b1;
        if (wr) begin
            if (size != 2'd3) begin
                for (int i = 0; i < nb; i++) begin
                    ai = 8'(int'(a) + i);
                    ref_mem[ai]   = 8'(d >> (8 * (nb - 1 - i)));
                    ref_known[ai] = 1'b1;
                end
                exp_wr_q.push_back('{a, d, size});
                exp_strobes++;
                wr_hist_q.push_back(a);
            end
        end else begin
            ev = '0;
            em = '0;
            if (size == 2'd3) begin
                em = 32'hFFFF_FFFF;
            end else begin
                for (int i = 0; i < nb; i++) begin
                    ai = 8'(int'(a) + i);
                    ev = (ev << 8) | (ref_known[ai] ? 32'(ref_mem[ai]) : 32'd0);
                    em = (em << 8) | (ref_known[ai] ? 32'hFF : 32'd0);
                end
            end
            exp_rd_q.push_back('{ev, em});
        end
        spi_frame(wr, size, addr, d, 99, !wr);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [11:0] raddr;
        for (int i = 0; i < 256; i++) begin
            ref_mem[i]   = 8'h00;
            ref_known[i] = 1'b0;
        end
        repeat (3) @(negedge clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_wr_strobe", 32'(wr_strobe), 32'd0);
        check("reset_wr_addr", 32'(wr_addr), 32'd0);
        check("reset_wr_data", wr_data, 32'd0);
        check("reset_wr_size", 32'(wr_size), 32'd0);
`ifdef SPI_SLAVE_ERR_EN
        check("reset_err_flags", 32'(err_flags), 32'd0);
`endif
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Directed frames; consecutive calls leave a 1-clk ss_n gap
        do_frame(1'b1, 2'd0, 12'h010, 32'h0000_00A5);
        do_frame(1'b1, 2'd2, 12'h0FE, 32'hDEAD_BEEF);
        do_frame(1'b0, 2'd1, 12'h0FE, 32'd0);
        do_frame(1'b0, 2'd2, 12'h0FE, 32'd0);
        do_frame(1'b1, 2'd1, 12'h3A0, 32'h0000_1234);
        do_frame(1'b0, 2'd1, 12'h3A0, 32'd0);
        do_frame(1'b0, 2'd0, 12'h010, 32'd0);

        // Deselect after 20 of 23 bits of an 8-bit write to 0x010
        spi_frame(1'b1, 2'd0, 12'h010, 32'h0000_005A, 20, 1'b0);
        repeat (6) @(negedge clk);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_strobes", 32'(strobe_cnt), 32'(exp_strobes));
`ifdef SPI_SLAVE_ERR_EN
        check("abort_err_flags", 32'(err_flags), 32'd1);
`endif
        do_frame(1'b0, 2'd0, 12'h010, 32'd0);

        // Reset in the middle of a read's data phase
        fork
            spi_frame(1'b0, 2'd2, 12'h0FE, 32'd0, 99, 1'b0);
            begin
                repeat (HALF * 2 * 25 + 2) @(negedge clk);
                check("midread_busy_before_reset", 32'(busy), 32'd1);
                rst_n = 1'b0;
                #1;
                check("midread_busy_in_reset", 32'(busy), 32'd0);
                check("midread_strobe_in_reset", 32'(wr_strobe), 32'd0);
            end
        join
        repeat (2) @(negedge clk);
        for (int i = 0; i < 256; i++) ref_known[i] = 1'b0;
        wr_hist_q.delete();
        saw_size3 = 1'b0;
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        do_frame(1'b1, 2'd2, 12'h020, 32'hCAFE_F00D);
        do_frame(1'b0, 2'd2, 12'h020, 32'd0);

        // Random traffic; reads mostly target previously written addresses
        for (int k = 0; k < 30; k++) begin
            raddr = 12'($urandom);
            if ($urandom_range(0, 3) != 0 && wr_hist_q.size() > 0)
                raddr = {4'($urandom), wr_hist_q[$urandom_range(0, wr_hist_q.size() - 1)]};
            do_frame(1'($urandom), 2'($urandom_range(0, 3)), raddr, $urandom);
        end

        repeat (40) @(negedge clk);
        check("wr_queue_drained", 32'(exp_wr_q.size()), 32'd0);
        check("rd_queue_drained", 32'(exp_rd_q.size()), 32'd0);
        check("total_strobes", 32'(strobe_cnt), 32'(exp_strobes));
`ifdef SPI_SLAVE_ERR_EN
        check("final_err_flags", 32'(err_flags), {30'd0, saw_size3, 1'b0});
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
